// File: rtl/rf_pkg.sv
// Shared types and constants for the RV32 integer register file.
//   XLEN       data width of every register and data port
//   NREGS      number of architectural registers (x0..x31)
//   AW         register address width, $clog2(NREGS)
//   word_t     one register value
//   reg_addr_t one register address
//   REG_ZERO   address of the hardwired-zero register x0
package rf_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Optional feature macro: RF_BYPASS_EN (write-through forwarding of the
// pending write data when the read address matches the write address).
// Ports:
//   raddr_i  read address
//   regs_i   storage array from the register file
//   we_i     write enable of the write port
//   waddr_i  write address of the write port
//   wdata_i  write data of the write port
//   rdata_o  read data; zero whenever raddr_i addresses x0
module rf_read_port
    import rf_pkg::*;
(
    input  logic [AW-1:0]   raddr_i,
    input  word_t           regs_i [NREGS],
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

`ifdef RF_BYPASS_EN
    always_comb begin
        rdata_o = regs_i[raddr_i];
        // Forward data that will only land in storage at the next edge.
        if (we_i && (waddr_i != REG_ZERO) && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
        if (raddr_i == REG_ZERO) begin
            rdata_o = '0;
        end
    end
`else
    // Write-port signals only feed the bypass path.
    logic unused_wr;
    assign unused_wr = ^{we_i, waddr_i, wdata_i};

    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (raddr_i == REG_ZERO) begin
            rdata_o = '0;
        end
    end
`endif

endmodule

// File: rtl/rv_regfile.sv
// RV32-style integer register file: 32 x 32-bit registers, two asynchronous
// read ports, one synchronous write port. x0 reads as zero and ignores writes.
// Optional feature macro: RF_BYPASS_EN (write-through forwarding on reads).
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset, clears all registers, beats writes
//   reg_s1   read port 1 address (rs1)
//   reg_s2   read port 2 address (rs2)
//   rd       write address
//   write_e  write enable
//   write_d  write data
//   reg_d1   read port 1 data
//   reg_d2   read port 2 data
module rv_regfile
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   reg_s1,
    input  logic [AW-1:0]   reg_s2,
    input  logic [AW-1:0]   rd,
    input  logic            write_e,
    input  logic [XLEN-1:0] write_d,
    output logic [XLEN-1:0] reg_d1,
    output logic [XLEN-1:0] reg_d2
);

    word_t regs_q [NREGS];
    word_t regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (write_e && (rd != REG_ZERO)) begin
            regs_d[rd] = write_d;
        end
    end

    // Entry 0 is cleared on reset and never written; the read ports mask it anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_read_port u_read_port1 (
        .raddr_i (reg_s1),
        .regs_i  (regs_q),
        .we_i    (write_e),
        .waddr_i (rd),
        .wdata_i (write_d),
        .rdata_o (reg_d1)
    );

    rf_read_port u_read_port2 (
        .raddr_i (reg_s2),
        .regs_i  (regs_q),
        .we_i    (write_e),
        .waddr_i (rd),
        .wdata_i (write_d),
        .rdata_o (reg_d2)
    );

endmodule

// File: tb/tb_rv_regfile.sv
// Self-checking bench for rv_regfile: directed scenarios followed by random
// traffic checked against an array-based reference model.
module tb_rv_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  reg_s1;
    logic [4:0]  reg_s2;
    logic [4:0]  rd;
    logic        write_e;
    logic [31:0] write_d;
    logic [31:0] reg_d1;
    logic [31:0] reg_d2;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] model [32];

    rv_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .reg_s1  (reg_s1),
        .reg_s2  (reg_s2),
        .rd      (rd),
        .write_e (write_e),
        .write_d (write_d),
        .reg_d1  (reg_d1),
        .reg_d2  (reg_d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural read value for the currently driven inputs.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (write_e && rd != 5'd0 && rd == a) return write_d;
`endif
        return model[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (write_e && rd != 5'd0) begin
            model[rd] = write_d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] s1, input logic [4:0] s2);
        rst     = r;
        write_e = we;
        rd      = a;
        write_d = d;
        reg_s1  = s1;
        reg_s2  = s2;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d, 5'd0, 5'd0);
        tick();
        write_e = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: everything reads zero after reset
        for (int a = 1; a < 32; a++) begin
            reg_s1 = 5'(a);
            reg_s2 = 5'(32 - a);
            #1;
            check_eq($sformatf("reset d1 x%0d", a), reg_d1, 32'd0);
            check_eq($sformatf("reset d2 x%0d", 32 - a), reg_d2, 32'd0);
        end

        // 2
        write_reg(5'd4, 32'd42);
        reg_s1 = 5'd4; reg_s2 = 5'd0; #1;
        check_eq("x4 write", reg_d1, 32'd42);
        check_eq("x0 read", reg_d2, 32'd0);

        // 3
        write_reg(5'd2, 32'd99);
        reg_s1 = 5'd2; reg_s2 = 5'd4; #1;
        check_eq("x2 write", reg_d1, 32'd99);
        check_eq("x4 retained", reg_d2, 32'd42);
        reg_s1 = 5'd4; #1;
        check_eq("same reg d1", reg_d1, 32'd42);
        check_eq("same reg d2", reg_d2, 32'd42);

        // 4: x0 ignores writes
        write_reg(5'd0, 32'hDEADBEEF);
        reg_s1 = 5'd0; #1;
        check_eq("x0 write dropped", reg_d1, 32'd0);

        // 5: disabled write, then reset beats write
        drive(1'b0, 1'b0, 5'd7, 32'd5, 5'd7, 5'd7);
        tick();
        check_eq("we=0 x7", reg_d1, 32'd0);
        write_reg(5'd3, 32'd123);
        reg_s1 = 5'd3; #1;
        check_eq("x3 pre reset", reg_d1, 32'd123);
        drive(1'b1, 1'b1, 5'd3, 32'd11, 5'd3, 5'd4);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        #1;
        check_eq("rst beats write x3", reg_d1, 32'd0);
        check_eq("rst clears x4", reg_d2, 32'd0);

        // 6: read during write
        write_reg(5'd9, 32'd5);
        drive(1'b0, 1'b1, 5'd9, 32'd77, 5'd9, 5'd0);
        #1;
`ifdef RF_BYPASS_EN
        check_eq("rdw before edge", reg_d1, 32'd77);
`else
        check_eq("rdw before edge", reg_d1, 32'd5);
`endif
        tick();
        write_e = 1'b0;
        #1;
        check_eq("rdw after edge", reg_d1, 32'd77);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a, $urandom(),
                  ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)));
            #1;
            check_eq($sformatf("rand pre d1 x%0d", reg_s1), reg_d1, model_read(reg_s1));
            check_eq($sformatf("rand pre d2 x%0d", reg_s2), reg_d2, model_read(reg_s2));
            tick();
            check_eq($sformatf("rand post d1 x%0d", reg_s1), reg_d1, model_read(reg_s1));
            check_eq($sformatf("rand post d2 x%0d", reg_s2), reg_d2, model_read(reg_s2));
        end

        // Final sweep of the whole file with writes disabled
        write_e = 1'b0;
        rst     = 1'b0;
        for (int a = 0; a < 32; a++) begin
            reg_s1 = 5'(a);
            reg_s2 = 5'(31 - a);
            #1;
            check_eq($sformatf("sweep d1 x%0d", a), reg_d1, model_read(reg_s1));
            check_eq($sformatf("sweep d2 x%0d", 31 - a), reg_d2, model_read(reg_s2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
